// File: rtl/wall_spawn_ctrl_if.sv
// wall_spawn_ctrl_if: renderer read port of the wall table.
//   rd_idx   - entry index requested by the renderer
//   rd_x/y   - stored tile origin at rd_idx (registered)
//   rd_valid - entry at rd_idx is occupied (registered)
// Modports: master = renderer side, slave = wall_spawn_ctrl side.
interface wall_spawn_ctrl_if #(
    parameter int unsigned MAX_WALLS = 8
);
    logic [$clog2(MAX_WALLS)-1:0] rd_idx;
    logic [10:0]                  rd_x;
    logic [10:0]                  rd_y;
    logic                         rd_valid;

    modport master (output rd_idx, input rd_x, input rd_y, input rd_valid);
    modport slave  (input rd_idx, output rd_x, output rd_y, output rd_valid);
endinterface

// File: rtl/wall_spawn_ctrl.sv
// wall_spawn_ctrl: sequences the wall position generator and owns the wall table.
// Counts game ticks; every SPAWN_PERIOD ticks samples a candidate, checks it against
// the head, the apple and every stored wall (one entry per cycle), then commits it
// into the lowest free entry or retries with the next generator value.
//
// Ports:
//   clk_i, btnrst_i        - clock, synchronous active-high reset
//   game_tick_i            - one-cycle pulse per game step
//   clear_walls_i          - empties the table and aborts any attempt
//   snakehead_x/y_i        - live snake head tile origin
//   apple_x/y_i            - live apple tile origin
//   newwall_x/y_i          - free-running candidate from the generator
//   rd_if                  - renderer read port (registered, 1-cycle latency)
//   wall_count_o           - occupied entries
//   wall_hit_o             - registered: head equals a valid wall
//   spawn_done_o/fail_o    - one-cycle pulses on commit / abandon
//   busy_o                 - attempt in progress (SAMPLE, CHECK, COMMIT)
//
// Optional feature: define WALL_SAFE_ZONE_EN to also reject candidates within
// 2*TILE_SIZE of the head on both axes (head tile plus its 8 neighbours).
module wall_spawn_ctrl #(
    parameter int unsigned MAX_WALLS    = 8,
    parameter int unsigned SPAWN_PERIOD = 16,
    parameter int unsigned MAX_RETRY    = 4,
    parameter int unsigned TILE_SIZE    = 32
) (
    input  logic                         clk_i,
    input  logic                         btnrst_i,
    input  logic                         game_tick_i,
    input  logic                         clear_walls_i,
    input  logic [10:0]                  snakehead_x_i,
    input  logic [10:0]                  snakehead_y_i,
    input  logic [10:0]                  apple_x_i,
    input  logic [10:0]                  apple_y_i,
    input  logic [10:0]                  newwall_x_i,
    input  logic [10:0]                  newwall_y_i,
    wall_spawn_ctrl_if.slave             rd_if,
    output logic [$clog2(MAX_WALLS):0]   wall_count_o,
    output logic                         wall_hit_o,
    output logic                         spawn_done_o,
    output logic                         spawn_fail_o,
    output logic                         busy_o
);
    localparam int unsigned IdxW   = $clog2(MAX_WALLS);
    localparam int unsigned CntW   = IdxW + 1;
    localparam int unsigned TickW  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {StIdle, StSample, StCheck, StCommit, StFull} state_e;

    state_e              state_q, state_d;
    logic [TickW-1:0]    tick_q, tick_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [10:0]         cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [MAX_WALLS-1:0] valid_q, valid_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [10:0]         wall_x_q [MAX_WALLS];
    logic [10:0]         wall_y_q [MAX_WALLS];
    logic                wall_hit_q;
    logic [10:0]         rd_x_q, rd_y_q;
    logic                rd_valid_q;

    logic                spawn_req;
    logic                wr_en;
    logic [IdxW-1:0]     free_idx;
    logic                hit_any;
    logic                reject;
    logic                safe_rej;

    // Request is raised by the wrapping tick; clear_walls suppresses it.
    assign spawn_req = game_tick_i && !clear_walls_i
                       && (tick_q == TickW'(SPAWN_PERIOD - 1));

    always_comb begin
        tick_d = tick_q;
        if (clear_walls_i) begin
            tick_d = '0;
        end else if (game_tick_i) begin
            tick_d = (tick_q == TickW'(SPAWN_PERIOD - 1)) ? '0 : tick_q + TickW'(1);
        end
    end

    // Lowest free entry; only used in COMMIT, where at least one entry is free.
    always_comb begin
        free_idx = '0;
        for (int i = int'(MAX_WALLS) - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IdxW'(i);
        end
    end

    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < int'(MAX_WALLS); i++) begin
            if (valid_q[i] && wall_x_q[i] == snakehead_x_i && wall_y_q[i] == snakehead_y_i) begin
                hit_any = 1'b1;
            end
        end
    end

`ifdef WALL_SAFE_ZONE_EN
    logic signed [11:0] dx, dy;
    logic        [11:0] adx, ady;
    assign dx  = $signed({1'b0, cand_x_q}) - $signed({1'b0, snakehead_x_i});
    assign dy  = $signed({1'b0, cand_y_q}) - $signed({1'b0, snakehead_y_i});
    assign adx = dx[11] ? 12'(-dx) : 12'(dx);
    assign ady = dy[11] ? 12'(-dy) : 12'(dy);
    assign safe_rej = (adx < 12'(2 * TILE_SIZE)) && (ady < 12'(2 * TILE_SIZE));
`else
    assign safe_rej = 1'b0;
`endif

    // Head and apple are compared live on every CHECK cycle; the table one entry per cycle.
    assign reject = (cand_x_q == snakehead_x_i && cand_y_q == snakehead_y_i)
                 || (cand_x_q == apple_x_i && cand_y_q == apple_y_i)
                 || (valid_q[idx_q] && wall_x_q[idx_q] == cand_x_q
                     && wall_y_q[idx_q] == cand_y_q)
                 || safe_rej;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        valid_d      = valid_q;
        count_d      = count_q;
        wr_en        = 1'b0;
        spawn_done_o = 1'b0;
        spawn_fail_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (spawn_req) begin
                    retry_d = '0;
                    state_d = StSample;
                end
            end
            StSample: begin
                cand_x_d = newwall_x_i;
                cand_y_d = newwall_y_i;
                idx_d    = '0;
                state_d  = StCheck;
            end
            StCheck: begin
                if (reject) begin
                    if (retry_q == RetryW'(MAX_RETRY - 1)) begin
                        retry_d      = '0;
                        spawn_fail_o = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StSample;
                    end
                end else if (idx_q == IdxW'(MAX_WALLS - 1)) begin
                    state_d = StCommit;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StCommit: begin
                wr_en             = 1'b1;
                valid_d[free_idx] = 1'b1;
                count_d           = count_q + CntW'(1);
                spawn_done_o      = 1'b1;
                state_d = (count_q == CntW'(MAX_WALLS - 1)) ? StFull : StIdle;
            end
            StFull: begin
                state_d = StFull;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Clear (and reset) abort silently and win over commit and tick.
        if (clear_walls_i || btnrst_i) begin
            state_d      = StIdle;
            valid_d      = '0;
            count_d      = '0;
            retry_d      = '0;
            wr_en        = 1'b0;
            spawn_done_o = 1'b0;
            spawn_fail_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (btnrst_i) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            retry_q    <= '0;
            idx_q      <= '0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            wall_hit_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            retry_q    <= retry_d;
            idx_q      <= idx_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            wall_hit_q <= hit_any;
            rd_x_q     <= wall_x_q[rd_if.rd_idx];
            rd_y_q     <= wall_y_q[rd_if.rd_idx];
            rd_valid_q <= valid_q[rd_if.rd_idx];
        end
    end

    // Table payload needs no reset; the valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            wall_x_q[free_idx] <= cand_x_q;
            wall_y_q[free_idx] <= cand_y_q;
        end
    end

    assign rd_if.rd_x     = rd_x_q;
    assign rd_if.rd_y     = rd_y_q;
    assign rd_if.rd_valid = rd_valid_q;
    assign wall_count_o   = count_q;
    assign wall_hit_o     = wall_hit_q;
    assign busy_o         = (state_q == StSample) || (state_q == StCheck)
                         || (state_q == StCommit);
endmodule

// File: doc/wall_spawn_ctrl.md
# wall_spawn_ctrl

Sequences the free-running wall position generator and owns the table of placed wall tiles. It counts game ticks and periodically samples a candidate position from the generator. The candidate is checked against the snake head, the apple and every stored wall, then committed or retried. Placed walls are exported to the VGA renderer through a read port, and a registered collision flag goes to game-over logic.

## Interface
Parameters:
- MAX_WALLS, 8, wall table depth; power of two, 2..16
- SPAWN_PERIOD, 16, game ticks between spawn attempts; must be 1 or greater
- MAX_RETRY, 4, candidates rejected before a spawn attempt is abandoned
- TILE_SIZE, 32, tile pitch in pixels, used for the safe-zone distance

Ports:
- clk  in  1  system clock
- btnrst  in  1  synchronous, active-high reset
- game_tick  in  1  one-cycle pulse per game step
- clear_walls  in  1  empties the table (new level)
- snakehead_x, snakehead_y  in  11 each  snake head tile origin
- apple_x, apple_y  in  11 each  apple tile origin
- newwall_x, newwall_y  in  11 each  candidate from the wall generator; advances every clk
- rd_idx  in  clog2(MAX_WALLS)  renderer read index
- rd_x, rd_y  out  11 each  stored entry at rd_idx
- rd_valid  out  1  entry at rd_idx is occupied
- wall_count  out  clog2(MAX_WALLS)+1  occupied entries
- wall_hit  out  1  snake head equals any valid wall
- spawn_done  out  1  one-cycle pulse on commit
- spawn_fail  out  1  one-cycle pulse on abandon (retries exhausted)
- busy  out  1  FSM not in IDLE/FULL

## Operation
- Tick counter: increments on game_tick and wraps to 0 at SPAWN_PERIOD-1. The wrap raises a spawn request.
  - Request in IDLE: starts an attempt.
  - Request in any other state: dropped. The counter still wraps.
- FSM states are IDLE, SAMPLE, CHECK, COMMIT and FULL.
  - IDLE to SAMPLE on a spawn request.
  - SAMPLE: latch newwall_x/y into cand, clear the entry index, go to CHECK.
  - CHECK: one table entry per cycle, MAX_WALLS cycles in total.
    - Reject if the candidate equals the head, equals the apple, or equals any valid entry.
    - On reject: increment retry. If retry reaches MAX_RETRY, pulse spawn_fail and go to IDLE; otherwise go to SAMPLE. The generator has advanced, so the next candidate differs.
    - When the last index passes, go to COMMIT.
  - COMMIT: write cand into the lowest free entry, set its valid bit, increment wall_count and pulse spawn_done.
    - Next state is FULL if wall_count reaches MAX_WALLS, else IDLE.
  - FULL: ignores spawn requests and leaves only on clear_walls or btnrst.
- Head and apple comparisons are taken from live inputs during CHECK, not latched.
- clear_walls: clears all valid bits, wall_count, retry and the tick counter, and returns the FSM to IDLE.
  - It aborts any attempt in progress without pulsing spawn_done or spawn_fail.
  - It wins over a simultaneous commit and over a simultaneous game_tick.
- wall_hit: a parallel compare of the head against all valid entries, registered. Equality is on the full 11 bits of both axes.
- Read port: rd_x, rd_y and rd_valid are registered from rd_idx.

## Timing
- Reset (btnrst sampled high at a clk edge):
  - FSM to IDLE.
  - Tick counter, retry, wall_count and all valid bits to 0.
  - Outputs wall_hit, spawn_done, spawn_fail, busy and rd_valid to 0.
  - rd_x and rd_y to 0.
  - Table payload is don't-care.
- Reset mid-attempt: same as above; no pulse is emitted.
- Successful spawn latency: SAMPLE 1 + CHECK MAX_WALLS + COMMIT 1 cycles after the request edge. That is 10 clk for the default, and spawn_done is high in cycle 10.
- Each reject adds 1 + (index at reject + 1) cycles.
- wall_hit: 1 cycle after the head or table changes. A wall committed onto the current head position is impossible by construction.
- Read port latency: 1 cycle after rd_idx is applied.
- busy: high from the cycle after the request through COMMIT inclusive.

## Configuration
- WALL_SAFE_ZONE_EN defined: CHECK additionally rejects when |cand_x - head_x| < 2*TILE_SIZE and |cand_y - head_y| < 2*TILE_SIZE.
  - Differences are computed 12-bit signed.
  - Walls never spawn in the head tile or its 8 neighbours.
- WALL_SAFE_ZONE_EN undefined: only exact-tile equality with the head is rejected.

## Test plan
- Reset, then 16 game_ticks with the head at (400,400) and the apple at (16,16), and generator output (80,176) held: spawn_done fires 10 cycles after the 16th tick, wall_count=1, and rd_idx=0 returns (80,176) with rd_valid=1.
- Generator held at the head position for the whole attempt: 4 rejects, then a spawn_fail pulse, wall_count unchanged, FSM back in IDLE.
- Eight successful spawns: wall_count=8 and the FSM is in FULL. A further 16 ticks produce no pulses. clear_walls then sets wall_count=0 and all rd_valid=0.
- Move the head onto the stored wall (80,176): wall_hit=1 one cycle later. Move the head to (112,176): wall_hit=0 one cycle later.
- Assert clear_walls in the COMMIT cycle: no spawn_done pulse, wall_count=0.
- With WALL_SAFE_ZONE_EN, head at (400,400) and candidate at (432,432): rejected. Without the macro the same candidate is committed.
